countdown_ctrl: RTL and testbench



---
 rtl/countdown_ctrl.sv | 150 +++++++++++++++
 tb/tb_countdown_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_ctrl.sv
// countdown_ctrl
//   Programmable countdown timer. It captures a start value, then decrements
//   once per prescaled tick. It supports pause/resume, abort and optional
//   auto-reload. Each terminal tick produces a one-cycle done pulse.
//
// Parameters
//   WIDTH     : bit width of the count and load value
//   PRESCALE  : clock cycles per decrement (1..255)
//
// Ports
//   clock       in   system clock, rising edge
//   reset_n     in   asynchronous reset, active-low
//   load_val    in   start value, captured when start is accepted in IDLE
//   start       in   start request (IDLE only)
//   pause       in   level-sensitive freeze request
//   abort       in   cancel, highest priority
//   auto_reload in   sampled on each terminal tick; 1 = restart from captured value
//   count       out  current counter value
//   busy        out  high in RUN or HOLD
//   paused      out  high in HOLD
//   done        out  one-cycle pulse on each terminal tick
module countdown_ctrl #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             paused,
  output logic             done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  // The prescaler counts down from PRESCALE-1; a tick is due when it hits 0.
  localparam logic [7:0] PRE_MAX = 8'(PRESCALE - 1);

  logic [1:0]       state_reg,  state_next;
  logic [WIDTH-1:0] count_reg,  count_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic [7:0]       presc_reg,  presc_next;
  logic             busy_reg,   busy_next;
  logic             paused_reg, paused_next;
  logic             done_reg,   done_next;

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    reload_next = reload_reg;
    presc_next  = presc_reg;
    done_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        // Abort in IDLE has no effect but still swallows a coincident start.
        if (!abort && start) begin
          if (load_val != '0) begin
            count_next  = load_val;
            reload_next = load_val;
            presc_next  = PRE_MAX;
            state_next  = RUN;
          end else begin
            // A zero load finishes immediately without ever going busy.
            done_next = 1'b1;
          end
        end
      end

      RUN: begin
        if (abort) begin
          state_next = IDLE;
          count_next = '0;
          presc_next = '0;
        end else if (pause) begin
          // Freeze everything, including a tick that would be due now.
          state_next = HOLD;
        end else if (presc_reg == 8'd0) begin
          presc_next = PRE_MAX;
          if (count_reg == WIDTH'(1)) begin
            done_next = 1'b1;
            if (auto_reload) begin
              count_next = reload_reg;
            end else begin
              count_next = '0;
              state_next = IDLE;
            end
          end else if (count_reg > WIDTH'(1)) begin
            count_next = count_reg - WIDTH'(1);
          end
        end else begin
          presc_next = presc_reg - 8'd1;
        end
      end

      HOLD: begin
        if (abort) begin
          state_next = IDLE;
          count_next = '0;
          presc_next = '0;
        end else if (!pause) begin
          // Resume cycle: back to RUN, no decrement, prescaler untouched.
          state_next = RUN;
        end
      end

      default: begin
        state_next = IDLE;
        count_next = '0;
        presc_next = '0;
      end
    endcase

    busy_next   = (state_next != IDLE);
    paused_next = (state_next == HOLD);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      reload_reg <= '0;
      presc_reg  <= '0;
      busy_reg   <= 1'b0;
      paused_reg <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      reload_reg <= reload_next;
      presc_reg  <= presc_next;
      busy_reg   <= busy_next;
      paused_reg <= paused_next;
      done_reg   <= done_next;
    end
  end

  assign count  = count_reg;
  assign busy   = busy_reg;
  assign paused = paused_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl
//   Drives two timers (PRESCALE=1 and PRESCALE=4) with the same directed
//   stimulus. A model tracks how many active RUN cycles have elapsed since
//   the last load, and derives count/done from that. Directed literal
//   expectations pin the model at key points.
module tb_countdown_ctrl;

  logic       clock;
  logic       reset_n;
  logic [3:0] load_val;
  logic       start, pause, abort, auto_reload;

  logic [3:0] cnt [2];
  logic       bsy [2];
  logic       psd [2];
  logic       dn  [2];

  int checks = 0;
  int errors = 0;

  countdown_ctrl #(.WIDTH(4), .PRESCALE(1)) dut_p1 (
    .clock(clock), .reset_n(reset_n), .load_val(load_val), .start(start),
    .pause(pause), .abort(abort), .auto_reload(auto_reload),
    .count(cnt[0]), .busy(bsy[0]), .paused(psd[0]), .done(dn[0])
  );

  countdown_ctrl #(.WIDTH(4), .PRESCALE(4)) dut_p4 (
    .clock(clock), .reset_n(reset_n), .load_val(load_val), .start(start),
    .pause(pause), .abort(abort), .auto_reload(auto_reload),
    .count(cnt[1]), .busy(bsy[1]), .paused(psd[1]), .done(dn[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- model ----------------
  int pre [2] = '{1, 4};
  bit m_busy [2];
  bit m_held [2];
  bit m_done [2];
  int m_load [2];
  int m_elapsed [2];   // un-paused RUN cycles since the last (re)load

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i]    <= 1'b0;
        m_held[i]    <= 1'b0;
        m_done[i]    <= 1'b0;
        m_load[i]    <= 0;
        m_elapsed[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin : step
        bit b, h, d;
        int ld, el;
        b = m_busy[i]; h = m_held[i]; d = 1'b0;
        ld = m_load[i]; el = m_elapsed[i];
        if (!b) begin
          if (!abort && start) begin
            if (load_val != 4'd0) begin
              b = 1'b1; h = 1'b0; ld = int'(load_val); el = 0;
            end else begin
              d = 1'b1;
            end
          end
        end else if (abort) begin
          b = 1'b0; h = 1'b0; el = 0;
        end else if (h) begin
          if (!pause) h = 1'b0;
        end else if (pause) begin
          h = 1'b1;
        end else begin
          el = el + 1;
          if (el == ld * pre[i]) begin
            d = 1'b1;
            if (auto_reload) el = 0;
            else b = 1'b0;
          end
        end
        m_busy[i]    <= b;
        m_held[i]    <= h;
        m_done[i]    <= d;
        m_load[i]    <= ld;
        m_elapsed[i] <= el;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      int exp_cnt;
      exp_cnt = m_busy[i] ? (m_load[i] - m_elapsed[i] / pre[i]) : 0;
      check($sformatf("model_count[%0d]", i), int'(cnt[i]), exp_cnt);
      check($sformatf("model_busy[%0d]", i), int'(bsy[i]), int'(m_busy[i]));
      check($sformatf("model_paused[%0d]", i), int'(psd[i]), int'(m_busy[i] & m_held[i]));
      check($sformatf("model_done[%0d]", i), int'(dn[i]), int'(m_done[i]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic clear();
    start = 1'b0; pause = 1'b0; auto_reload = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  task automatic do_start(input logic [3:0] v);
    load_val = v; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int n;
    reset_n = 1'b0; load_val = '0; start = 0; pause = 0; abort = 0; auto_reload = 0;
    tick(); tick();
    check("reset_count", int'(cnt[0]), 0);
    check("reset_busy", int'(bsy[0]), 0);
    reset_n = 1'b1;
    tick();

    // Reset mid-count, checked before the next clock edge.
    do_start(4'd5);
    check("midrst_pre_count", int'(cnt[0]), 5);
    tick();
    check("midrst_pre_count2", int'(cnt[0]), 4);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_count", int'(cnt[0]), 0);
    check("midrst_busy", int'(bsy[0]), 0);
    check("midrst_done", int'(dn[0]), 0);
    check("midrst_count_p4", int'(cnt[1]), 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Basic countdown, PRESCALE=1.
    do_start(4'd3);
    check("basic_c3", int'(cnt[0]), 3);
    check("basic_busy", int'(bsy[0]), 1);
    tick(); check("basic_c2", int'(cnt[0]), 2);
    tick(); check("basic_c1", int'(cnt[0]), 1);
    check("basic_nodone", int'(dn[0]), 0);
    tick(); check("basic_c0", int'(cnt[0]), 0);
    check("basic_done", int'(dn[0]), 1);
    check("basic_busy_drop", int'(bsy[0]), 0);
    tick(); check("basic_done_clr", int'(dn[0]), 0);
    clear();

    // Prescaled auto-reload on the PRESCALE=4 instance.
    auto_reload = 1'b1;
    do_start(4'd2);
    for (int k = 0; k <= 24; k++) begin
      check($sformatf("ar_count_k%0d", k), int'(cnt[1]), ((k % 8) < 4) ? 2 : 1);
      check($sformatf("ar_done_k%0d", k), int'(dn[1]), (k > 0 && (k % 8) == 0) ? 1 : 0);
      check($sformatf("ar_busy_k%0d", k), int'(bsy[1]), 1);
      tick();
    end
    clear();

    // Pause/resume, PRESCALE=1.
    do_start(4'd6);
    tick(); tick();
    check("pause_pre_c4", int'(cnt[0]), 4);
    pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("pause_hold_k%0d", k), int'(cnt[0]), 4);
      check($sformatf("pause_paused_k%0d", k), int'(psd[0]), 1);
    end
    pause = 1'b0;
    tick();
    check("resume_c4", int'(cnt[0]), 4);
    check("resume_paused", int'(psd[0]), 0);
    for (int v = 3; v >= 0; v--) begin
      tick();
      check($sformatf("resume_c%0d", v), int'(cnt[0]), v);
    end
    check("resume_done", int'(dn[0]), 1);
    clear();

    // Abort with pause in HOLD.
    do_start(4'd5);
    tick(); tick();
    pause = 1'b1;
    tick();
    check("hold_c3", int'(cnt[0]), 3);
    check("hold_paused", int'(psd[0]), 1);
    abort = 1'b1;
    tick();
    check("abort_count", int'(cnt[0]), 0);
    check("abort_busy", int'(bsy[0]), 0);
    check("abort_paused", int'(psd[0]), 0);
    check("abort_nodone", int'(dn[0]), 0);
    abort = 1'b0; pause = 1'b0;
    tick();
    check("abort_nodone2", int'(dn[0]), 0);

    // Abort and start together in IDLE.
    abort = 1'b1; load_val = 4'd7; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("idle_abort_start_busy", int'(bsy[0]), 0);
    check("idle_abort_start_count", int'(cnt[0]), 0);
    tick();
    check("idle_abort_start_busy2", int'(bsy[0]), 0);
    clear();

    // Zero load: done one cycle later, never busy.
    do_start(4'd0);
    check("zero_done", int'(dn[0]), 1);
    check("zero_busy", int'(bsy[0]), 0);
    check("zero_done_p4", int'(dn[1]), 1);
    tick();
    check("zero_done_clr", int'(dn[0]), 0);
    check("zero_busy2", int'(bsy[0]), 0);
    clear();

    // Maximum load, PRESCALE=1: done exactly 15 cycles after the first RUN cycle.
    do_start(4'd15);
    check("max_c15", int'(cnt[0]), 15);
    n = 41;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (dn[0]) begin
        n = k;
        break;
      end
    end
    check("max_done_cycle", n, 15);
    clear();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
